id_exe_stage_reg: RTL and testbench



---
 rtl/id_exe_stage_reg.sv | 178 +++++++++++++++++
 tb/tb_id_exe_stage_reg.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_exe_stage_reg.sv
// id_exe_stage_reg
// Pipeline register between the ID and EXE stages of the 5-stage ARM core.
// Captures decoded control and operand fields every cycle. It inserts a bubble
// when the hazard detector stalls ID, clears on a taken branch, and holds all
// state while the memory stage freezes the pipeline.
//
// Each rising edge applies one action, highest priority first:
// rst, freeze, flush, hazard_detected, load.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   freeze                   hold every register, including the counter
//   flush                    zero all fields and clear valid_out
//   hazard_detected          zero control fields, capture data, count a bubble
//   *_in / *_out             decoded control, operands, PC, indices, C flag
//   valid_out                EXE slot holds a real instruction
//   bubble_count             saturating count of hazard bubbles
//
// Build option:
//   BUBBLE_COUNT_EN  defined   -> 32-bit saturating bubble counter is built
//                    undefined -> bubble_count is tied to zero

`ifndef REG_FILE_DEPTH
`define REG_FILE_DEPTH 4
`endif

module id_exe_stage_reg #(
  parameter int WORD_W = 32,
  parameter int REG_W  = `REG_FILE_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              hazard_detected,
  input  logic              WB_EN_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              B_in,
  input  logic              S_in,
  input  logic [3:0]        EXE_CMD_in,
  input  logic [WORD_W-1:0] pc_in,
  input  logic [WORD_W-1:0] val_Rn_in,
  input  logic [WORD_W-1:0] val_Rm_in,
  input  logic              imm_in,
  input  logic [11:0]       shift_operand_in,
  input  logic [23:0]       signed_imm_24_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [REG_W-1:0]  src1_in,
  input  logic [REG_W-1:0]  src2_in,
  input  logic              carry_in,
  output logic              WB_EN_out,
  output logic              MEM_R_EN_out,
  output logic              MEM_W_EN_out,
  output logic              B_out,
  output logic              S_out,
  output logic [3:0]        EXE_CMD_out,
  output logic [WORD_W-1:0] pc_out,
  output logic [WORD_W-1:0] val_Rn_out,
  output logic [WORD_W-1:0] val_Rm_out,
  output logic              imm_out,
  output logic [11:0]       shift_operand_out,
  output logic [23:0]       signed_imm_24_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [REG_W-1:0]  src1_out,
  output logic [REG_W-1:0]  src2_out,
  output logic              carry_out,
  output logic              valid_out,
  output logic [31:0]       bubble_count
);

  // Control fields are the ones a bubble must kill; data fields ride along.
  typedef struct packed {
    logic       wb_en;
    logic       mem_r_en;
    logic       mem_w_en;
    logic       b;
    logic       s;
    logic [3:0] exe_cmd;
  } ctrl_t;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] val_rn;
    logic [WORD_W-1:0] val_rm;
    logic              imm;
    logic [11:0]       shift_operand;
    logic [23:0]       signed_imm_24;
    logic [REG_W-1:0]  dest;
    logic [REG_W-1:0]  src1;
    logic [REG_W-1:0]  src2;
    logic              carry;
  } data_t;

  ctrl_t ctrl_in, ctrl_d, ctrl_q;
  data_t data_in, data_d, data_q;
  logic  valid_d, valid_q;

  assign ctrl_in = '{wb_en: WB_EN_in, mem_r_en: MEM_R_EN_in, mem_w_en: MEM_W_EN_in,
                     b: B_in, s: S_in, exe_cmd: EXE_CMD_in};

  assign data_in = '{pc: pc_in, val_rn: val_Rn_in, val_rm: val_Rm_in, imm: imm_in,
                     shift_operand: shift_operand_in, signed_imm_24: signed_imm_24_in,
                     dest: dest_in, src1: src1_in, src2: src2_in, carry: carry_in};

  always_comb begin
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    valid_d = valid_q;
    if (freeze) begin
      // hold everything: the EXE branch that would flush is frozen too
    end else if (flush) begin
      ctrl_d  = '0;
      data_d  = '0;
      valid_d = 1'b0;
    end else if (hazard_detected) begin
      // Bubble: WB_EN=0 keeps the hazard detector from matching on this slot.
      ctrl_d  = '0;
      data_d  = data_in;
      valid_d = 1'b0;
    end else begin
      ctrl_d  = ctrl_in;
      data_d  = data_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign WB_EN_out         = ctrl_q.wb_en;
  assign MEM_R_EN_out      = ctrl_q.mem_r_en;
  assign MEM_W_EN_out      = ctrl_q.mem_w_en;
  assign B_out             = ctrl_q.b;
  assign S_out             = ctrl_q.s;
  assign EXE_CMD_out       = ctrl_q.exe_cmd;
  assign pc_out            = data_q.pc;
  assign val_Rn_out        = data_q.val_rn;
  assign val_Rm_out        = data_q.val_rm;
  assign imm_out           = data_q.imm;
  assign shift_operand_out = data_q.shift_operand;
  assign signed_imm_24_out = data_q.signed_imm_24;
  assign dest_out          = data_q.dest;
  assign src1_out          = data_q.src1;
  assign src2_out          = data_q.src2;
  assign carry_out         = data_q.carry;
  assign valid_out         = valid_q;

`ifdef BUBBLE_COUNT_EN
  logic [31:0] bubble_q, bubble_d;

  // Only a real bubble counts: freeze and flush both take priority over hazard.
  always_comb begin
    bubble_d = bubble_q;
    if (!freeze && !flush && hazard_detected && (bubble_q != 32'hFFFF_FFFF))
      bubble_d = bubble_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) bubble_q <= '0;
    else     bubble_q <= bubble_d;
  end

  assign bubble_count = bubble_q;
`else
  assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_exe_stage_reg.sv
module tb_id_exe_stage_reg;

  typedef struct packed {
    logic        wb, mr, mw, b, s;
    logic [3:0]  cmd;
    logic [31:0] pc, rn, rm;
    logic        imm;
    logic [11:0] sh;
    logic [23:0] off;
    logic [3:0]  dest, src1, src2;
    logic        carry;
  } in_t;

  typedef struct packed {
    in_t         f;
    logic        valid;
    logic [31:0] bc;
  } out_t;

  logic clk = 1'b0;
  logic rst, freeze, flush, hazard;
  in_t  in_s;
  out_t act, exp_m;

  logic        wb_o, mr_o, mw_o, b_o, s_o, imm_o, carry_o, valid_o;
  logic [3:0]  cmd_o, dest_o, src1_o, src2_o;
  logic [31:0] pc_o, rn_o, rm_o, bc_o;
  logic [11:0] sh_o;
  logic [23:0] off_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.WORD_W(32), .REG_W(4)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .hazard_detected(hazard),
    .WB_EN_in(in_s.wb), .MEM_R_EN_in(in_s.mr), .MEM_W_EN_in(in_s.mw),
    .B_in(in_s.b), .S_in(in_s.s), .EXE_CMD_in(in_s.cmd), .pc_in(in_s.pc),
    .val_Rn_in(in_s.rn), .val_Rm_in(in_s.rm), .imm_in(in_s.imm),
    .shift_operand_in(in_s.sh), .signed_imm_24_in(in_s.off), .dest_in(in_s.dest),
    .src1_in(in_s.src1), .src2_in(in_s.src2), .carry_in(in_s.carry),
    .WB_EN_out(wb_o), .MEM_R_EN_out(mr_o), .MEM_W_EN_out(mw_o), .B_out(b_o),
    .S_out(s_o), .EXE_CMD_out(cmd_o), .pc_out(pc_o), .val_Rn_out(rn_o),
    .val_Rm_out(rm_o), .imm_out(imm_o), .shift_operand_out(sh_o),
    .signed_imm_24_out(off_o), .dest_out(dest_o), .src1_out(src1_o),
    .src2_out(src2_o), .carry_out(carry_o), .valid_out(valid_o), .bubble_count(bc_o)
  );

  assign act = {wb_o, mr_o, mw_o, b_o, s_o, cmd_o, pc_o, rn_o, rm_o, imm_o, sh_o,
                off_o, dest_o, src1_o, src2_o, carry_o, valid_o, bc_o};

  // Reference: one edge applies the highest-priority action.
  function automatic out_t model_next(out_t m, logic r, logic fz, logic fl, logic hz, in_t i);
    out_t n = m;
    if (r) begin
      n = '0;
    end else if (fz) begin
      n = m;
    end else if (fl) begin
      n.f = '0;
      n.valid = 1'b0;
    end else if (hz) begin
      n.f = i;
      n.f.wb = 0; n.f.mr = 0; n.f.mw = 0; n.f.b = 0; n.f.s = 0; n.f.cmd = 4'd0;
      n.valid = 1'b0;
`ifdef BUBBLE_COUNT_EN
      if (m.bc != 32'hFFFF_FFFF) n.bc = m.bc + 32'd1;
`endif
    end else begin
      n.f = i;
      n.valid = 1'b1;
    end
    return n;
  endfunction

  function automatic in_t rand_in();
    in_t r;
    r.wb = 1'($urandom); r.mr = 1'($urandom); r.mw = 1'($urandom);
    r.b = 1'($urandom); r.s = 1'($urandom); r.cmd = 4'($urandom);
    r.pc = $urandom; r.rn = $urandom; r.rm = $urandom; r.imm = 1'($urandom);
    r.sh = 12'($urandom); r.off = 24'($urandom); r.dest = 4'($urandom);
    r.src1 = 4'($urandom); r.src2 = 4'($urandom); r.carry = 1'($urandom);
    return r;
  endfunction

  // Apply one edge, advance the model, sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    exp_m = model_next(exp_m, rst, freeze, flush, hazard, in_s);
    #1;
  endtask

  task automatic set_ctl(logic r, logic fz, logic fl, logic hz);
    rst = r; freeze = fz; flush = fl; hazard = hz;
  endtask

  task automatic test_reset();
    in_s = rand_in();
    set_ctl(1, 0, 0, 1);
    step();
    n_cmp++;
    if (act !== '0) begin
      n_err++;
      $display("FAIL reset: got %h want 0", act);
    end
    n_cmp++;
    if (act !== exp_m) begin
      n_err++;
      $display("FAIL reset_model: got %h want %h", act, exp_m);
    end
  endtask

  task automatic test_load_and_hazard();
    in_s = '0;
    in_s.wb = 1; in_s.cmd = 4'b0010; in_s.dest = 4'd3; in_s.rn = 32'h1234;
    set_ctl(0, 0, 0, 0);
    step();
    n_cmp++;
    if (wb_o !== 1'b1 || cmd_o !== 4'b0010 || dest_o !== 4'd3 || rn_o !== 32'h1234 || valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL load: got wb=%b cmd=%h dest=%h rn=%h valid=%b want 1 2 3 1234 1",
               wb_o, cmd_o, dest_o, rn_o, valid_o);
    end
    set_ctl(0, 0, 0, 1);
    step();
    n_cmp++;
    if (wb_o !== 1'b0 || cmd_o !== 4'd0 || valid_o !== 1'b0 || dest_o !== 4'd3 || rn_o !== 32'h1234) begin
      n_err++;
      $display("FAIL hazard_bubble: got wb=%b cmd=%h valid=%b dest=%h rn=%h want 0 0 0 3 1234",
               wb_o, cmd_o, valid_o, dest_o, rn_o);
    end
`ifdef BUBBLE_COUNT_EN
    n_cmp++;
    if (bc_o !== 32'd1) begin
      n_err++;
      $display("FAIL bubble_count_inc: got %0d want 1", bc_o);
    end
`endif
    n_cmp++;
    if (act !== exp_m) begin
      n_err++;
      $display("FAIL hazard_model: got %h want %h", act, exp_m);
    end
  endtask

  task automatic test_flush_beats_hazard();
    logic [31:0] bc_before;
    bc_before = exp_m.bc;
    in_s = rand_in();
    in_s.rm = 32'hFFFF;
    set_ctl(0, 0, 1, 1);
    step();
    n_cmp++;
    if ({act.f, act.valid} !== '0) begin
      n_err++;
      $display("FAIL flush_hazard: got %h want 0", {act.f, act.valid});
    end
    n_cmp++;
    if (bc_o !== bc_before) begin
      n_err++;
      $display("FAIL flush_bubble_count: got %0d want %0d", bc_o, bc_before);
    end
  endtask

  task automatic test_freeze_beats_flush();
    in_s = rand_in();
    in_s.dest = 4'd7;
    set_ctl(0, 0, 0, 0);
    step();
    for (int k = 0; k < 3; k++) begin
      in_s = rand_in();
      set_ctl(0, 1, 1, k[0]);
      step();
      n_cmp++;
      if (dest_o !== 4'd7 || valid_o !== 1'b1 || act !== exp_m) begin
        n_err++;
        $display("FAIL freeze_hold[%0d]: got dest=%h valid=%b all=%h want dest=7 valid=1 all=%h",
                 k, dest_o, valid_o, act, exp_m);
      end
    end
    in_s = rand_in();
    set_ctl(0, 0, 0, 0);
    step();
    n_cmp++;
    if (act.f !== in_s || valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL freeze_release_load: got %h want %h", act.f, in_s);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      in_s = rand_in();
      set_ctl(0, 0, 0, 1);
      step();
      n_cmp++;
      if (act !== exp_m) begin
        n_err++;
        $display("FAIL b2b_bubble[%0d]: got %h want %h", k, act, exp_m);
      end
    end
    in_s = rand_in();
    set_ctl(0, 0, 0, 0);
    step();
    n_cmp++;
    if (act !== exp_m || valid_o !== 1'b1) begin
      n_err++;
      $display("FAIL b2b_load: got %h want %h", act, exp_m);
    end
  endtask

  task automatic test_saturation();
`ifdef BUBBLE_COUNT_EN
    set_ctl(0, 1, 0, 0);
    step();
    force dut.bubble_q = 32'hFFFF_FFFE;
    #1;
    release dut.bubble_q;
    exp_m.bc = 32'hFFFF_FFFE;
`endif
    for (int k = 0; k < 3; k++) begin
      in_s = rand_in();
      set_ctl(0, 0, 0, 1);
      step();
    end
    n_cmp++;
`ifdef BUBBLE_COUNT_EN
    if (bc_o !== 32'hFFFF_FFFF) begin
      n_err++;
      $display("FAIL saturation: got %h want ffffffff", bc_o);
    end
`else
    if (bc_o !== 32'd0) begin
      n_err++;
      $display("FAIL count_disabled: got %h want 0", bc_o);
    end
`endif
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      in_s = rand_in();
      set_ctl(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
              ($urandom_range(0, 6) == 0), ($urandom_range(0, 3) == 0));
      step();
      n_cmp++;
      if (act !== exp_m) begin
        n_err++;
        $display("FAIL random[%0d]: got %h want %h", k, act, exp_m);
      end
    end
  endtask

  initial begin
    exp_m = '0;
    in_s = '0;
    set_ctl(1, 0, 0, 0);
    #1;
    test_reset();
    test_load_and_hazard();
    test_flush_beats_hazard();
    test_freeze_beats_flush();
    test_back_to_back();
    test_random();
    test_saturation();
    test_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
